divn_seq: RTL and testbench
===========================

Name: divn_seq

Overview:
Parametrised sequential radix-2 non-restoring integer divider. It is the successor to the fixed 32-bit divider and adds configurable width, a signed/unsigned mode, divide-by-zero flagging, back-to-back operation and an optional early-termination shortcut. It serves the flight-controller datapath (PID scaling, sensor normalisation) through a start/done handshake.

Parameters:
WIDTH, 32, operand and result width in bits (legal range 4..64).
CNT_W, $clog2(WIDTH+1), width of the iteration counter (derived; do not override).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
en  in  1  clock enable; when 0, all state and outputs hold.
start  in  1  request a division; sampled only when accepting.
signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; latched at start.
dividend  in  WIDTH  numerator; latched at start.
divisor  in  WIDTH  denominator; latched at start.
quotient  out  WIDTH  result, registered.
remainder  out  WIDTH  result, registered.
done  out  1  single-cycle pulse: results valid.
busy  out  1  high while an operation is in flight.
div_by_zero  out  1  set with done when divisor was 0.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE; quotient=0, remainder=0, done=0, busy=0, div_by_zero=0. Reset takes priority over en and aborts any operation in flight. No done pulse follows an aborted operation.
- States: IDLE, CALC, FIXUP, DONE. Each transition requires en=1.
- Accept: start=1 with state IDLE or DONE. Operands, signed_mode and |dividend|, |divisor| are latched. busy=1 from the next cycle. start is ignored in CALC and FIXUP.
- divisor==0 at accept: go directly to DONE. quotient = all ones, remainder = dividend (raw), div_by_zero=1. done is high 1 edge after the accept edge.
- Normal path: CALC runs exactly WIDTH iterations, one quotient bit per edge, counter WIDTH-1 down to 0. The partial remainder is WIDTH+1 bits wide. CALC is followed by one FIXUP cycle, which performs the final remainder restore and sign correction.
- Latency: done is high in the cycle after WIDTH+2 rising edges from the accept edge (34 for WIDTH=32).
- Signed rules: the quotient truncates toward zero; the remainder takes the sign of the dividend. Most-negative / -1 gives quotient = most-negative and remainder = 0, with no flag.
- Unsigned: operands are treated as magnitudes directly.
- DONE lasts one cycle, with done=1 and busy=0, then returns to IDLE unless a new start is accepted in that cycle (back-to-back).
- quotient, remainder and div_by_zero update only on entry to DONE and hold until the next DONE entry.
- en=0 in any state freezes the state, counter, outputs and the level of done; the operation resumes when en returns to 1.

Optional Feature:
DIV_EARLY_TERM_EN:
- Defined: if |dividend| < |divisor| (divisor nonzero) at accept, CALC and FIXUP are skipped. quotient=0, remainder=dividend (raw, signed-correct). done is high 1 edge after accept.
- Undefined: every nonzero-divisor operation takes the full WIDTH+2 latency. Results are identical either way.

Test Plan:
- WIDTH=32, unsigned 1000/25 -> quotient=40, remainder=0, done exactly 34 edges after accept, busy high for 33 cycles.
- Unsigned 32'h3FFFFFFF/12345 -> quotient=86977, remainder=10758. Follow immediately with start in the DONE cycle, 500/7 -> quotient=71, remainder=3 (back-to-back accepted).
- Signed -7/2 -> quotient=-3 (32'hFFFFFFFD), remainder=-1. Signed 32'h80000000/-1 -> quotient=32'h80000000, remainder=0, div_by_zero=0.
- 5/0 in either mode -> quotient=32'hFFFFFFFF, remainder=5, div_by_zero=1, done 1 edge after accept. The next normal divide clears div_by_zero.
- Start 1000/25, assert a new start with different operands at cycle 5 -> ignored, result still 40/0. Assert rst at cycle 10 -> outputs 0, busy=0, no done pulse. Drop en for 7 cycles mid-CALC -> done arrives 7 cycles late with the correct result.
- With DIV_EARLY_TERM_EN: 3/10 -> quotient=0, remainder=3, done 1 edge after accept. Without it: same result at 34 edges.

Source files
------------

// File: rtl/divn_seq.sv
// divn_seq: sequential radix-2 non-restoring integer divider, WIDTH-bit operands.
// The divider supports signed and unsigned operands, flags a zero divisor, and
// can accept a new start in the DONE cycle so operations run back-to-back.
// Optional macro DIV_EARLY_TERM_EN: when |dividend| < |divisor| at accept,
// the iterations are skipped and the result is produced on the next edge.
module divn_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     p_q, p_d;        // signed partial remainder, one guard bit
  logic [WIDTH-1:0]   a_q, a_d;        // dividend magnitude shifting out, quotient bits shifting in
  logic [WIDTH-1:0]   d_q, d_d;        // divisor magnitude
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH-1:0]   dvd_abs, dsr_abs;
  logic [WIDTH:0]     shifted, p_step;
  logic [WIDTH-1:0]   a_step, r_mag;
  logic               accept;

  // Operand magnitudes and one non-restoring iteration step.
  always_comb begin
    dvd_abs = (signed_mode && dividend[WIDTH-1]) ? -dividend : dividend;
    dsr_abs = (signed_mode && divisor[WIDTH-1])  ? -divisor  : divisor;
    shifted = {p_q[WIDTH-1:0], a_q[WIDTH-1]};
    // A negative partial remainder adds the divisor back instead of subtracting.
    p_step  = p_q[WIDTH] ? (shifted + {1'b0, d_q}) : (shifted - {1'b0, d_q});
    a_step  = {a_q[WIDTH-2:0], ~p_step[WIDTH]};
    // Final restore: a negative remainder lies in [-D,0), so adding D in WIDTH bits is exact.
    r_mag   = p_q[WIDTH] ? (p_q[WIDTH-1:0] + d_q) : p_q[WIDTH-1:0];
  end

  // Next-state and datapath updates; every register holds unless its state acts on it.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    p_d         = p_q;
    a_d         = a_q;
    d_d         = d_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    accept      = start && ((state_q == IDLE) || (state_q == DONE));

    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) begin
          state_d = IDLE;
        end
        if (accept) begin
          neg_quo_d = signed_mode && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_rem_d = signed_mode && dividend[WIDTH-1];
          if (divisor == '0) begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end
`ifdef DIV_EARLY_TERM_EN
          else if (dvd_abs < dsr_abs) begin
            state_d     = DONE;
            quotient_d  = '0;
            remainder_d = dividend;
            dbz_d       = 1'b0;
          end
`endif
          else begin
            state_d = CALC;
            cnt_d   = CNT_INIT;
            p_d     = '0;
            a_d     = dvd_abs;
            d_d     = dsr_abs;
          end
        end
      end
      CALC: begin
        p_d = p_step;
        a_d = a_step;
        if (cnt_q == '0) begin
          state_d = FIXUP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      FIXUP: begin
        state_d     = DONE;
        quotient_d  = neg_quo_q ? -a_q : a_q;
        remainder_d = neg_rem_q ? -r_mag : r_mag;
        dbz_d       = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register: reset wins over en; en=0 freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      p_q         <= '0;
      a_q         <= '0;
      d_q         <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else if (en) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      a_q         <= a_d;
      d_q         <= d_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign done        = (state_q == DONE);
  assign busy        = (state_q == CALC) || (state_q == FIXUP);

endmodule

// File: tb/tb_divn_seq.sv
// tb_divn_seq: directed bench for divn_seq (WIDTH=32) with an arithmetic reference model.
module tb_divn_seq;
  localparam int W = 32;
`ifdef DIV_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, en, start, signed_mode;
  logic [W-1:0] dividend, divisor, quotient, remainder;
  logic         done, busy, div_by_zero;
  logic         en_seen = 1'b0;
  int           checks = 0;
  int           errors = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } exp_t;
  exp_t exp_fifo[$];

  always #5 clk = ~clk;

  divn_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .signed_mode(signed_mode),
    .dividend(dividend), .divisor(divisor), .quotient(quotient),
    .remainder(remainder), .done(done), .busy(busy), .div_by_zero(div_by_zero)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference: plain integer arithmetic (truncating division, remainder follows dividend).
  function automatic exp_t model(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa, sb;
    if (b == '0) begin
      e.q = '1; e.r = a; e.z = 1'b1;
    end else if (sm) begin
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      e.q = W'(sa / sb);
      e.r = W'(sa % sb);
      e.z = 1'b0;
    end else begin
      e.q = a / b; e.r = a % b; e.z = 1'b0;
    end
    return e;
  endfunction

  always @(posedge clk) en_seen <= en;

  // Every enabled edge that leaves done high is a fresh DONE entry: check it against the model.
  always @(negedge clk) begin
    exp_t e;
    if (done && en_seen) begin
      if (exp_fifo.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1, expected no pending operation");
      end else begin
        e = exp_fifo.pop_front();
        check("model_quotient", quotient, e.q);
        check("model_remainder", remainder, e.r);
        check("model_dbz", div_by_zero, e.z);
      end
    end
  end

  task automatic issue(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b);
    signed_mode = sm;
    dividend    = a;
    divisor     = b;
    start       = 1'b1;
    exp_fifo.push_back(model(sm, a, b));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Edge count includes the accept edge; returns at the negedge where done is seen.
  task automatic wait_done(input string tag, input logic [W-1:0] eq, input logic [W-1:0] er,
                           input logic ez, input int exp_lat, input int exp_busy,
                           input int ign_at, input int drop_at);
    int edges;
    int busy_cyc;
    bit seen;
    edges    = 1;
    busy_cyc = 0;
    seen     = 1'b0;
    while (edges < 300) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cyc++;
      if (ign_at == edges) begin
        start = 1'b1; dividend = 32'd777; divisor = 32'd3;
      end else if (ign_at + 1 == edges) begin
        start = 1'b0;
      end
      if (drop_at == edges) en = 1'b0;
      if (drop_at + 7 == edges) en = 1'b1;
      @(posedge clk);
      edges++;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done after %0d edges, expected done at %0d", tag, edges, exp_lat);
    end else begin
      check({tag, "_latency"}, edges, exp_lat);
      check({tag, "_busy_cycles"}, busy_cyc, exp_busy);
      check({tag, "_busy_at_done"}, busy, 0);
      check({tag, "_quotient"}, quotient, eq);
      check({tag, "_remainder"}, remainder, er);
      check({tag, "_dbz"}, div_by_zero, ez);
    end
    $display("op %s: q=%h r=%h dbz=%b edges=%0d busy_cycles=%0d", tag, quotient, remainder,
             div_by_zero, edges, busy_cyc);
  endtask

  initial begin
    int saw_done;
    int lat_short;
    int busy_short;
    rst = 1'b1; en = 1'b1; start = 1'b0; signed_mode = 1'b0;
    dividend = '0; divisor = '0;
    lat_short  = ET ? 1 : 34;
    busy_short = ET ? 0 : 33;
    repeat (3) @(posedge clk);
    #1;
    check("reset_quotient", quotient, 0);
    check("reset_remainder", remainder, 0);
    check("reset_done", done, 0);
    check("reset_busy", busy, 0);
    check("reset_dbz", div_by_zero, 0);
    rst = 1'b0;
    @(negedge clk);

    issue(1'b0, 32'd1000, 32'd25);
    wait_done("u1000_25", 32'd40, 32'd0, 1'b0, 34, 33, -1, -1);
    issue(1'b0, 32'h3FFFFFFF, 32'd12345);
    wait_done("u3fffffff_12345", 32'd86977, 32'd10758, 1'b0, 34, 33, -1, -1);
    // Issued in the DONE cycle of the previous operation.
    issue(1'b0, 32'd500, 32'd7);
    wait_done("u500_7_b2b", 32'd71, 32'd3, 1'b0, 34, 33, -1, -1);
    issue(1'b1, 32'hFFFFFFF9, 32'd2);
    wait_done("s-7_2", 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34, 33, -1, -1);
    issue(1'b1, 32'h80000000, 32'hFFFFFFFF);
    wait_done("smin_-1", 32'h80000000, 32'd0, 1'b0, 34, 33, -1, -1);
    issue(1'b0, 32'd5, 32'd0);
    wait_done("u5_0", 32'hFFFFFFFF, 32'd5, 1'b1, 1, 0, -1, -1);
    issue(1'b1, 32'd5, 32'd0);
    wait_done("s5_0", 32'hFFFFFFFF, 32'd5, 1'b1, 1, 0, -1, -1);
    issue(1'b1, 32'd100, 32'hFFFFFFF9);
    wait_done("s100_-7", 32'hFFFFFFF2, 32'd2, 1'b0, 34, 33, -1, -1);
    issue(1'b1, 32'hFFFFFF9C, 32'd7);
    wait_done("s-100_7", 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 34, 33, -1, -1);
    issue(1'b0, 32'hFFFFFFFF, 32'd1);
    wait_done("uffffffff_1", 32'hFFFFFFFF, 32'd0, 1'b0, 34, 33, -1, -1);
    issue(1'b0, 32'd1000, 32'd25);
    wait_done("u1000_25_ignstart", 32'd40, 32'd0, 1'b0, 34, 33, 5, -1);

    // Abort an operation in flight with reset.
    @(negedge clk);
    issue(1'b0, 32'd1000, 32'd25);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    exp_fifo.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    saw_done = 0;
    repeat (60) begin
      @(negedge clk);
      if (done) saw_done++;
    end
    check("abort_no_done", saw_done, 0);
    $display("op abort: q=%h r=%h busy=%b done_pulses=%0d", quotient, remainder, busy, saw_done);

    issue(1'b0, 32'd1000, 32'd25);
    wait_done("u1000_25_endrop", 32'd40, 32'd0, 1'b0, 41, 40, -1, 10);
    issue(1'b0, 32'd3, 32'd10);
    wait_done("u3_10", 32'd0, 32'd3, 1'b0, lat_short, busy_short, -1, -1);
    issue(1'b1, 32'hFFFFFFFD, 32'd10);
    wait_done("s-3_10", 32'd0, 32'hFFFFFFFD, 1'b0, lat_short, busy_short, -1, -1);

    @(negedge clk);
    @(negedge clk);
    check("pending_empty", exp_fifo.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
